// File: rtl/score_match_ctrl.sv
// score_match_ctrl: ping-pong match sequencer.
// Keeps scores, sequences serve/rally/hold/game-over, flashes winner.
module score_match_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int FLASH_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [3:0] p1s,
  output logic [3:0] p2s,
  output logic       ball_en,
  output logic       ball_rst,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic       blank1,
  output logic       blank2
);

  localparam int MAXC =
    (HOLD_CYCLES > FLASH_CYCLES) ? HOLD_CYCLES : FLASH_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_CYCLES - 1);
  localparam logic [3:0]    WIN4       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    RALLY,
    HOLD,
    OVER
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    p1s_n, p2s_n;
  logic          dir_n, win_n;
  logic          flash, flash_n;
  logic          p1_only, p2_only, both;

  assign p1_only = p1_point & ~p2_point;
  assign p2_only = p2_point & ~p1_point;
  assign both    = p1_point & p2_point;

  // Next-state, score and flash-phase decisions.
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    p1s_n   = p1s;
    p2s_n   = p2s;
    dir_n   = serve_dir;
    win_n   = winner;
    flash_n = flash;
    unique case (state)
      IDLE: begin
        if (start) state_n = SERVE;
      end
      SERVE: begin
        state_n = RALLY;
      end
      RALLY: begin
        if (p1_only) begin
          if (p1s < WIN4) p1s_n = p1s + 4'd1;
          dir_n = 1'b1;
          if (p1s_n == WIN4) begin
            state_n = OVER;
            win_n   = 1'b0;
          end else begin
            state_n = HOLD;
          end
        end else if (p2_only) begin
          if (p2s < WIN4) p2s_n = p2s + 4'd1;
          dir_n = 1'b0;
          if (p2s_n == WIN4) begin
            state_n = OVER;
            win_n   = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end else if (both) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) state_n = SERVE;
        else cnt_n = cnt + 1'b1;
      end
      OVER: begin
        if (start) begin
          state_n = SERVE;
          p1s_n   = '0;
          p2s_n   = '0;
        end else if (cnt == FLASH_LAST) begin
          flash_n = ~flash;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) begin
      cnt_n   = '0;
      flash_n = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      flash     <= 1'b0;
      p1s       <= '0;
      p2s       <= '0;
      ball_en   <= 1'b0;
      ball_rst  <= 1'b0;
      serve_dir <= 1'b0;
      game_over <= 1'b0;
      winner    <= 1'b0;
      blank1    <= 1'b0;
      blank2    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      flash     <= flash_n;
      p1s       <= p1s_n;
      p2s       <= p2s_n;
      ball_en   <= (state_n == RALLY);
      ball_rst  <= (state_n == SERVE);
      serve_dir <= dir_n;
      game_over <= (state_n == OVER);
      winner    <= win_n;
      blank1    <= (state_n == OVER) & flash_n & ~win_n;
      blank2    <= (state_n == OVER) & flash_n & win_n;
    end
  end

endmodule

// File: tb/tb_score_match_ctrl.sv
// tb_score_match_ctrl: directed plan plus random stimulus
// against an edge-indexed behavioural model.
module tb_score_match_ctrl;

  localparam int WIN   = 3;
  localparam int HOLDC = 4;
  localparam int FLSH  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [3:0] p1s, p2s;
  logic       ball_en, ball_rst, serve_dir;
  logic       game_over, winner, blank1, blank2;

  score_match_ctrl #(
    .WIN_SCORE   (WIN),
    .HOLD_CYCLES (HOLDC),
    .FLASH_CYCLES(FLSH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .p1_point (p1_point),
    .p2_point (p2_point),
    .p1s      (p1s),
    .p2s      (p2s),
    .ball_en  (ball_en),
    .ball_rst (ball_rst),
    .serve_dir(serve_dir),
    .game_over(game_over),
    .winner   (winner),
    .blank1   (blank1),
    .blank2   (blank2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 playing, 2 match over.
  // serve_at is the edge after which the ball is re-centred;
  // over_at is the edge on which the match ended.
  int t = 0;
  int m_mode = 0;
  int m_p1 = 0, m_p2 = 0;
  int m_dir = 0, m_win = 0;
  int serve_at = -100;
  int over_at = 0;

  task automatic check(input string tag, input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %0d expected %0d",
                  tag, t, got, exp);
  endtask

  task automatic score(input int who);
    if (who == 1) begin
      if (m_p1 < WIN) m_p1++;
      m_dir = 1;
      if (m_p1 == WIN) begin
        m_mode = 2; over_at = t; m_win = 0;
      end else serve_at = t + HOLDC;
    end else begin
      if (m_p2 < WIN) m_p2++;
      m_dir = 0;
      if (m_p2 == WIN) begin
        m_mode = 2; over_at = t; m_win = 1;
      end else serve_at = t + HOLDC;
    end
  endtask

  task automatic model(input logic r, input logic s,
                       input logic a, input logic b);
    t++;
    if (!r) begin
      m_mode = 0; m_p1 = 0; m_p2 = 0;
      m_dir = 0; m_win = 0; serve_at = -100;
    end else if (m_mode == 0) begin
      if (s) begin m_mode = 1; serve_at = t; end
    end else if (m_mode == 1) begin
      if (t - 1 > serve_at) begin
        if (a && b) serve_at = t + HOLDC;
        else if (a) score(1);
        else if (b) score(2);
      end
    end else begin
      if (s) begin
        m_mode = 1; m_p1 = 0; m_p2 = 0; serve_at = t;
      end
    end
  endtask

  task automatic compare();
    int ph;
    ph = (m_mode == 2) ? ((t - over_at) / FLSH) % 2 : 0;
    check("p1s", int'(p1s), m_p1);
    check("p2s", int'(p2s), m_p2);
    check("ball_en", int'(ball_en),
          int'(m_mode == 1 && t > serve_at));
    check("ball_rst", int'(ball_rst),
          int'(m_mode == 1 && t == serve_at));
    check("serve_dir", int'(serve_dir), m_dir);
    check("game_over", int'(game_over), int'(m_mode == 2));
    check("winner", int'(winner), m_win);
    check("blank1", int'(blank1), int'(ph == 1 && m_win == 0));
    check("blank2", int'(blank2), int'(ph == 1 && m_win == 1));
  endtask

  task automatic step(input logic r, input logic s,
                      input logic a, input logic b);
    reset = r; start = s; p1_point = a; p2_point = b;
    @(posedge clk);
    model(r, s, a, b);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0);
  endtask

  initial begin
    // Reset, start, serve, rally.
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    check("serve_pulse", int'(ball_rst), 1);
    idle(2);
    check("rally_en", int'(ball_en), 1);
    // Single points and hold/serve timing.
    step(1, 0, 1, 0);
    check("p1_first", int'(p1s), 1);
    idle(7);
    step(1, 0, 0, 1);
    check("p2_first", int'(p2s), 1);
    idle(7);
    // Replay, then point during hold ignored.
    step(1, 0, 1, 1);
    step(1, 0, 1, 0);
    idle(7);
    // Player 2 wins; flash, then dropped points.
    step(1, 0, 0, 1);
    idle(7);
    step(1, 0, 0, 1);
    check("p2_wins", int'(p2s), WIN);
    idle(8);
    step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    idle(2);
    // Restart from game over.
    step(1, 1, 0, 0);
    check("restart_clr", int'(p2s), 0);
    idle(3);
    // Reset mid-hold with p1s = 2.
    step(1, 0, 1, 0);
    idle(7);
    step(1, 0, 1, 0);
    idle(2);
    step(0, 1, 0, 0);
    check("rst_mid_hold", int'(p1s), 0);
    idle(3);
    step(1, 1, 0, 0);
    idle(3);
    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
